sysid_checker: RTL and testbench

SYSID_CHECKER -- requirements
Module: sysid_checker

---
 rtl/sysid_checker_pkg.sv | 19 +
 rtl/sysid_checker.sv | 157 +++++++++++++++
 tb/tb_sysid_checker.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sysid_checker_pkg.sv
// rtl/sysid_checker_pkg.sv - state encoding, slave word addresses and watchdog width for sysid_checker
package sysid_checker_pkg;

   typedef enum logic [2:0] {
      IDLE,
      RD_ID,
      LAT_ID,
      RD_TS,
      LAT_TS,
      FIN
   } state_t;

   localparam logic ADDR_ID = 1'b0;
   localparam logic ADDR_TS = 1'b1;

   localparam int TMO_W = 16;
   typedef logic [TMO_W-1:0] tmo_cnt_t;

endpackage

// File: rtl/sysid_checker.sv
// rtl/sysid_checker.sv - reads the sysid slave ID and timestamp words over Avalon-MM and compares them
// Optional watchdog abort enabled by defining SYSID_CHECKER_TIMEOUT_EN.
module sysid_checker
   import sysid_checker_pkg::*;
#(
   parameter logic [31:0] EXPECTED_ID    = 32'd34566365,
   parameter logic [31:0] EXPECTED_TS    = 32'd1568289510,
   parameter int          READ_LATENCY   = 1,
   parameter int          TIMEOUT_CYCLES = 1024
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   output logic        avm_address,
   output logic        avm_read,
   input  logic        avm_waitrequest,
   input  logic [31:0] avm_readdata,
   output logic        busy,
   output logic        done,
   output logic        id_ok,
   output logic        ts_ok,
   output logic [31:0] id_value,
   output logic [31:0] ts_value,
   output logic        timeout
);

   localparam logic [1:0] LAT = READ_LATENCY[1:0];

   state_t     state;
   state_t     state_next;
   logic [1:0] lat_cnt;
   logic       cap_id;
   logic       cap_ts;
   logic       tmo_fire;

`ifdef SYSID_CHECKER_TIMEOUT_EN
   localparam tmo_cnt_t TMO_LAST = tmo_cnt_t'(TIMEOUT_CYCLES - 1);
   tmo_cnt_t tmo_cnt;
   logic     timeout_q;
`endif

   always_comb begin
      state_next = state;
      cap_id     = 1'b0;
      cap_ts     = 1'b0;
      tmo_fire   = 1'b0;
      case (state)
         IDLE: begin
            if (start) state_next = RD_ID;
         end
         RD_ID: begin
            if (!avm_waitrequest) begin
               if (LAT == 2'd0) begin
                  cap_id     = 1'b1;
                  state_next = RD_TS;
               end else begin
                  state_next = LAT_ID;
               end
            end
         end
         LAT_ID: begin
            if (lat_cnt == LAT) begin
               cap_id     = 1'b1;
               state_next = RD_TS;
            end
         end
         RD_TS: begin
            if (!avm_waitrequest) begin
               if (LAT == 2'd0) begin
                  cap_ts     = 1'b1;
                  state_next = FIN;
               end else begin
                  state_next = LAT_TS;
               end
            end
         end
         LAT_TS: begin
            if (lat_cnt == LAT) begin
               cap_ts     = 1'b1;
               state_next = FIN;
            end
         end
         FIN: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
`ifdef SYSID_CHECKER_TIMEOUT_EN
      // The watchdog wins over a capture landing in the same cycle.
      if (state != IDLE && state != FIN && tmo_cnt == TMO_LAST) begin
         tmo_fire   = 1'b1;
         cap_id     = 1'b0;
         cap_ts     = 1'b0;
         state_next = FIN;
      end
`endif
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= IDLE;
         lat_cnt  <= 2'd0;
         id_ok    <= 1'b0;
         ts_ok    <= 1'b0;
         id_value <= 32'd0;
         ts_value <= 32'd0;
      end else begin
         state <= state_next;
         if (state == RD_ID || state == RD_TS) begin
            lat_cnt <= 2'd1;
         end else if (state == LAT_ID || state == LAT_TS) begin
            lat_cnt <= lat_cnt + 2'd1;
         end
         if (state == IDLE && start) begin
            id_ok <= 1'b0;
            ts_ok <= 1'b0;
         end
         if (cap_id) begin
            id_value <= avm_readdata;
            id_ok    <= (avm_readdata == EXPECTED_ID);
         end
         if (cap_ts) begin
            ts_value <= avm_readdata;
            ts_ok    <= (avm_readdata == EXPECTED_TS);
         end
      end
   end

`ifdef SYSID_CHECKER_TIMEOUT_EN
   always_ff @(posedge clock) begin
      if (reset) begin
         tmo_cnt   <= '0;
         timeout_q <= 1'b0;
      end else begin
         if (state == IDLE && start) begin
            tmo_cnt   <= '0;
            timeout_q <= 1'b0;
         end else if (state != IDLE) begin
            tmo_cnt <= tmo_cnt + 1'b1;
         end
         if (tmo_fire) timeout_q <= 1'b1;
      end
   end

   assign timeout = timeout_q;
`else
   assign timeout = 1'b0;
`endif

   assign busy        = (state != IDLE);
   assign done        = (state == FIN);
   assign avm_read    = (state == RD_ID) || (state == RD_TS);
   assign avm_address = (state == RD_TS) ? ADDR_TS : ADDR_ID;

endmodule

// File: tb/tb_sysid_checker.sv
// tb/tb_sysid_checker.sv - randomized self-checking bench for sysid_checker at read latencies 0, 1 and 3
// Honours SYSID_CHECKER_TIMEOUT_EN for the stalled-slave scenario.
module tb_sysid_checker;

   localparam logic [31:0] EXP_ID = 32'd34566365;
   localparam logic [31:0] EXP_TS = 32'd1568289510;
   localparam int LATS [3] = '{0, 1, 3};

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [2:0]  start = 3'b000;
   logic [2:0]  wreq = 3'b000;
   logic [2:0]  avm_read, avm_address, busy, done, id_ok, ts_ok, timeout;
   logic [31:0] rdata [3];
   logic [31:0] id_value [3];
   logic [31:0] ts_value [3];
   logic [31:0] mem_id [3] = '{EXP_ID, EXP_ID, EXP_ID};
   logic [31:0] mem_ts [3] = '{EXP_TS, EXP_TS, EXP_TS};

   int   cyc = 0;
   int   due [3] = '{-1, -1, -1};
   logic paddr [3] = '{1'b0, 1'b0, 1'b0};
   int   pass_cnt = 0;
   int   check_cnt = 0;

   always #5 clock = ~clock;

   sysid_checker #(.READ_LATENCY(0), .TIMEOUT_CYCLES(16)) u_l0 (
      .clock(clock), .reset(reset), .start(start[0]),
      .avm_address(avm_address[0]), .avm_read(avm_read[0]),
      .avm_waitrequest(wreq[0]), .avm_readdata(rdata[0]),
      .busy(busy[0]), .done(done[0]), .id_ok(id_ok[0]), .ts_ok(ts_ok[0]),
      .id_value(id_value[0]), .ts_value(ts_value[0]), .timeout(timeout[0]));

   sysid_checker #(.READ_LATENCY(1), .TIMEOUT_CYCLES(16)) u_l1 (
      .clock(clock), .reset(reset), .start(start[1]),
      .avm_address(avm_address[1]), .avm_read(avm_read[1]),
      .avm_waitrequest(wreq[1]), .avm_readdata(rdata[1]),
      .busy(busy[1]), .done(done[1]), .id_ok(id_ok[1]), .ts_ok(ts_ok[1]),
      .id_value(id_value[1]), .ts_value(ts_value[1]), .timeout(timeout[1]));

   sysid_checker #(.READ_LATENCY(3), .TIMEOUT_CYCLES(16)) u_l3 (
      .clock(clock), .reset(reset), .start(start[2]),
      .avm_address(avm_address[2]), .avm_read(avm_read[2]),
      .avm_waitrequest(wreq[2]), .avm_readdata(rdata[2]),
      .busy(busy[2]), .done(done[2]), .id_ok(id_ok[2]), .ts_ok(ts_ok[2]),
      .id_value(id_value[2]), .ts_value(ts_value[2]), .timeout(timeout[2]));

   // Slave model: data is valid only in the exact cycle it is due, inverted junk otherwise.
   always @(posedge clock) begin
      cyc <= cyc + 1;
      for (int i = 0; i < 3; i++) begin
         if (avm_read[i] === 1'b1 && wreq[i] === 1'b0) begin
            due[i]   <= cyc + LATS[i];
            paddr[i] <= avm_address[i];
         end
      end
   end

   always_comb begin
      for (int i = 0; i < 3; i++) begin
         rdata[i] = 32'd0;
         if (LATS[i] == 0) begin
            if (avm_read[i] === 1'b1 && wreq[i] === 1'b0)
               rdata[i] = avm_address[i] ? mem_ts[i] : mem_id[i];
            else
               rdata[i] = avm_address[i] ? ~mem_ts[i] : ~mem_id[i];
         end else begin
            if (due[i] == cyc)
               rdata[i] = paddr[i] ? mem_ts[i] : mem_id[i];
            else
               rdata[i] = paddr[i] ? ~mem_ts[i] : ~mem_id[i];
         end
      end
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // Runs one sequence on instance i; reports start-to-done latency (-1 if none), done count and read stability.
   task automatic drive_seq(input int i, input logic [31:0] idw, input logic [31:0] tsw,
                            input int nwait, input bit extra,
                            output int lat, output int ndone, output bit stable);
      int first;
      mem_id[i] = idw;
      mem_ts[i] = tsw;
      start[i]  = 1'b1;
      wreq[i]   = 1'b0;
      first     = -1;
      ndone     = 0;
      stable    = 1'b1;
      step();
      for (int k = 1; k <= 80; k++) begin
         start[i] = 1'b0;
         wreq[i]  = (k <= nwait);
         if (extra && k == 2) start[i] = 1'b1;
         if (k <= nwait && busy[i] === 1'b1 && done[i] !== 1'b1 &&
             (avm_read[i] !== 1'b1 || avm_address[i] !== 1'b0)) stable = 1'b0;
         if (done[i] === 1'b1) begin
            ndone++;
            if (first < 0) first = k;
            if (extra) start[i] = 1'b1;
         end
         if (first >= 0 && k >= first + 3) break;
         step();
      end
      start[i] = 1'b0;
      wreq[i]  = 1'b0;
      lat      = first;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step();
      step();
      for (int i = 0; i < 3; i++) begin
         check_cnt++;
         if ({busy[i], done[i], avm_read[i], avm_address[i], id_ok[i], ts_ok[i], timeout[i]} !== 7'd0)
            $display("FAIL reset_flags inst=%0d got=%b want=0000000", i,
                     {busy[i], done[i], avm_read[i], avm_address[i], id_ok[i], ts_ok[i], timeout[i]});
         else pass_cnt++;
         check_cnt++;
         if (id_value[i] !== 32'd0 || ts_value[i] !== 32'd0)
            $display("FAIL reset_values inst=%0d got=%h/%h want=0/0", i, id_value[i], ts_value[i]);
         else pass_cnt++;
      end
      reset = 1'b0;
      step();
   endtask

   task automatic test_match();
      int lat, nd;
      bit st;
      for (int i = 0; i < 3; i++) begin
         drive_seq(i, EXP_ID, EXP_TS, 0, 1'b0, lat, nd, st);
         check_cnt++;
         if (lat !== 2 * (1 + LATS[i]) + 1 || nd !== 1)
            $display("FAIL match_timing inst=%0d lat=%0d ndone=%0d want lat=%0d ndone=1", i, lat, nd, 2 * (1 + LATS[i]) + 1);
         else pass_cnt++;
         check_cnt++;
         if (id_ok[i] !== 1'b1 || ts_ok[i] !== 1'b1 || id_value[i] !== EXP_ID || ts_value[i] !== EXP_TS)
            $display("FAIL match_data inst=%0d ok=%b%b id=%0d ts=%0d want ok=11 id=%0d ts=%0d",
                     i, id_ok[i], ts_ok[i], id_value[i], ts_value[i], EXP_ID, EXP_TS);
         else pass_cnt++;
      end
   endtask

   task automatic test_ts_zero();
      int lat, nd;
      bit st;
      drive_seq(1, EXP_ID, 32'd0, 0, 1'b0, lat, nd, st);
      check_cnt++;
      if (nd !== 1 || id_ok[1] !== 1'b1 || ts_ok[1] !== 1'b0 || ts_value[1] !== 32'd0)
         $display("FAIL ts_zero ndone=%0d ok=%b%b ts=%h want ndone=1 ok=10 ts=0", nd, id_ok[1], ts_ok[1], ts_value[1]);
      else pass_cnt++;
   endtask

   task automatic test_wait7();
      int lat, nd;
      bit st;
      drive_seq(1, EXP_ID, EXP_TS, 7, 1'b0, lat, nd, st);
      check_cnt++;
      if (st !== 1'b1)
         $display("FAIL wait7_stable got=%b want=1", st);
      else pass_cnt++;
      check_cnt++;
      if (lat !== 5 + 7 || nd !== 1 || id_ok[1] !== 1'b1 || ts_ok[1] !== 1'b1)
         $display("FAIL wait7_done lat=%0d ndone=%0d ok=%b%b want lat=12 ndone=1 ok=11", lat, nd, id_ok[1], ts_ok[1]);
      else pass_cnt++;
   endtask

   task automatic test_reset_mid();
      int lat, nd;
      bit st;
      mem_id[1] = EXP_ID;
      mem_ts[1] = EXP_TS;
      start[1]  = 1'b1;
      step();
      start[1]  = 1'b0;
      step();
      step();
      step();
      check_cnt++;
      if (id_value[1] !== EXP_ID || busy[1] !== 1'b1 || avm_read[1] !== 1'b0)
         $display("FAIL pre_reset id=%0d busy=%b read=%b want id=%0d busy=1 read=0", id_value[1], busy[1], avm_read[1], EXP_ID);
      else pass_cnt++;
      reset = 1'b1;
      step();
      reset = 1'b0;
      check_cnt++;
      if ({done[1], busy[1], avm_read[1], id_ok[1], ts_ok[1]} !== 5'd0 || id_value[1] !== 32'd0 || ts_value[1] !== 32'd0)
         $display("FAIL reset_mid done=%b busy=%b read=%b ok=%b%b id=%h ts=%h want all 0",
                  done[1], busy[1], avm_read[1], id_ok[1], ts_ok[1], id_value[1], ts_value[1]);
      else pass_cnt++;
      step();
      drive_seq(1, EXP_ID, EXP_TS, 0, 1'b0, lat, nd, st);
      check_cnt++;
      if (lat !== 5 || nd !== 1 || id_ok[1] !== 1'b1 || ts_ok[1] !== 1'b1)
         $display("FAIL after_reset lat=%0d ndone=%0d ok=%b%b want lat=5 ndone=1 ok=11", lat, nd, id_ok[1], ts_ok[1]);
      else pass_cnt++;
   endtask

   task automatic test_busy_start();
      int lat, nd;
      bit st;
      for (int i = 0; i < 3; i += 2) begin
         drive_seq(i, EXP_ID, EXP_TS, 0, 1'b1, lat, nd, st);
         check_cnt++;
         if (lat !== 2 * (1 + LATS[i]) + 1 || nd !== 1 || busy[i] !== 1'b0)
            $display("FAIL busy_start inst=%0d lat=%0d ndone=%0d busy=%b want lat=%0d ndone=1 busy=0",
                     i, lat, nd, busy[i], 2 * (1 + LATS[i]) + 1);
         else pass_cnt++;
         check_cnt++;
         if (id_value[i] !== EXP_ID || ts_value[i] !== EXP_TS || id_ok[i] !== 1'b1 || ts_ok[i] !== 1'b1)
            $display("FAIL busy_start_data inst=%0d id=%0d ts=%0d ok=%b%b want id=%0d ts=%0d ok=11",
                     i, id_value[i], ts_value[i], id_ok[i], ts_ok[i], EXP_ID, EXP_TS);
         else pass_cnt++;
      end
   endtask

   task automatic test_stall();
      int lat, nd;
      bit st;
      drive_seq(1, EXP_ID, EXP_TS, 30, 1'b0, lat, nd, st);
`ifdef SYSID_CHECKER_TIMEOUT_EN
      check_cnt++;
      if (lat !== 17 || nd !== 1 || timeout[1] !== 1'b1 || id_ok[1] !== 1'b0 || ts_ok[1] !== 1'b0)
         $display("FAIL stall_timeout lat=%0d ndone=%0d tmo=%b ok=%b%b want lat=17 ndone=1 tmo=1 ok=00",
                  lat, nd, timeout[1], id_ok[1], ts_ok[1]);
      else pass_cnt++;
`else
      check_cnt++;
      if (lat !== 5 + 30 || nd !== 1 || timeout[1] !== 1'b0 || st !== 1'b1)
         $display("FAIL stall_hold lat=%0d ndone=%0d tmo=%b stable=%b want lat=35 ndone=1 tmo=0 stable=1",
                  lat, nd, timeout[1], st);
      else pass_cnt++;
`endif
   endtask

   task automatic test_random();
      int lat, nd, i, nwait;
      bit st;
      logic [31:0] idw, tsw;
      for (int n = 0; n < 12; n++) begin
         i     = $urandom_range(0, 2);
         idw   = ($urandom_range(0, 1) == 1) ? EXP_ID : $urandom;
         tsw   = ($urandom_range(0, 1) == 1) ? EXP_TS : $urandom;
         nwait = $urandom_range(0, 5);
         drive_seq(i, idw, tsw, nwait, 1'b0, lat, nd, st);
         check_cnt++;
         if (lat !== 2 * (1 + LATS[i]) + 1 + nwait || nd !== 1 || timeout[i] !== 1'b0)
            $display("FAIL rand_timing n=%0d inst=%0d lat=%0d ndone=%0d tmo=%b want lat=%0d ndone=1 tmo=0",
                     n, i, lat, nd, timeout[i], 2 * (1 + LATS[i]) + 1 + nwait);
         else pass_cnt++;
         check_cnt++;
         if (id_value[i] !== idw || ts_value[i] !== tsw ||
             id_ok[i] !== (idw == EXP_ID) || ts_ok[i] !== (tsw == EXP_TS))
            $display("FAIL rand_data n=%0d inst=%0d id=%h ts=%h ok=%b%b want id=%h ts=%h ok=%b%b",
                     n, i, id_value[i], ts_value[i], id_ok[i], ts_ok[i], idw, tsw, idw == EXP_ID, tsw == EXP_TS);
         else pass_cnt++;
      end
   endtask

   initial begin
      test_reset();
      test_match();
      test_ts_zero();
      test_wait7();
      test_reset_mid();
      test_busy_start();
      test_stall();
      test_random();
      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule
